keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Parametrised matrix-keypad scanner: drives NUM_ROWS row lines one-hot, reads NUM_COLS column lines.
//  Adds programmable scan dwell, debounce on both press and release, one-shot press/release strobes
//  and a held-key level. Sits between the keypad pins and the RAT input port / interrupt logic.
// PARAMETERS
//  NUM_ROWS        4      number of driven row lines (>=2)
//  NUM_COLS        3      number of sensed column lines (>=1)
//  SCAN_DIV        50000  clk cycles each row is driven per dwell (>=3)
//  DEBOUNCE_SCANS  4      consecutive matching samples needed to accept press or release (>=1)
//  CODE_W          localparam: $clog2(NUM_ROWS*NUM_COLS), or 4 when KEYPAD_PHONE_MAP_EN is defined
// PORTS
//  clk          in   1         system clock; single clock domain
//  rst_n        in   1         synchronous reset, active-low
//  col_in       in   NUM_COLS  raw column lines, active-high, asynchronous to clk
//  row_drv      out  NUM_ROWS  one-hot row drive, registered
//  key_code     out  CODE_W    code of current/last accepted key, registered, held until next press
//  key_press    out  1         one-cycle strobe when a press is accepted; key_code valid same cycle
//  key_release  out  1         one-cycle strobe when the held key's release is accepted
//  key_down     out  1         level: high from the key_press cycle through the key_release cycle
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): row_drv=1 (row 0), key_code=0, key_press=0, key_release=0,
//   key_down=0, dwell counter=0, match counter=0, FSM=SCAN. Reset mid-debounce or mid-hold drops
//   the key silently; no strobe is issued.
//  col_in passes through a 2-FF synchronizer (col_s); all decisions use col_s only.
//  Dwell: counter runs 0..SCAN_DIV-1 on the driven row; the "sample" is col_s at count SCAN_DIV-1.
//  Column select: when col_s is non-zero, the lowest-index set bit wins (c).
//  FSM:
//   SCAN     : at each sample, if col_s==0, advance row_drv to the next row (NUM_ROWS-1 wraps to 0).
//              Otherwise latch row r and column c, match=1, go to DEBOUNCE (row_drv stays on r).
//   DEBOUNCE : each sample: col_s[c]==1 -> match++; col_s[c]==0 -> go to SCAN, advance row.
//              When match reaches DEBOUNCE_SCANS: key_code=map(r,c), key_press=1 and key_down=1
//              on the next cycle; go to HELD. DEBOUNCE_SCANS=1 accepts on the first sample.
//   HELD     : row_drv stays on r; other keys are ignored (no rollover). Each sample: col_s[c]==0
//              -> match++; col_s[c]==1 -> match=0. When match reaches DEBOUNCE_SCANS:
//              key_release=1 for one cycle, key_down=0 the cycle after, go to SCAN, advance row.
//  Latency: key_press is asserted 1 cycle after the DEBOUNCE_SCANS-th matching sample. A held key
//   produces exactly one key_press; there is no auto-repeat.
//  Default map: map(r,c) = r*NUM_COLS + c, truncated to CODE_W.
//  The dwell counter is $clog2(SCAN_DIV) wide and resets to 0 on every row change and state change.
// CONFIGURATION
//  KEYPAD_PHONE_MAP_EN defined: CODE_W=4 and telephone layout map: row0 -> 1,2,3; row1 -> 4,5,6;
//   row2 -> 7,8,9; row3 -> 10(*),0,11(#). The parameter check raises $error unless
//   NUM_ROWS==4 and NUM_COLS==3.
//  KEYPAD_PHONE_MAP_EN undefined: default linear map, any NUM_ROWS/NUM_COLS.
// TESTING  (SCAN_DIV=4, DEBOUNCE_SCANS=3, NUM_ROWS=4, NUM_COLS=3 unless noted)
//  1 Reset: hold rst_n=0 for 2 clk -> row_drv=4'b0001, all strobes 0, key_code=0.
//  2 Clean press: col_in=3'b100 only while row_drv=4'b0010, held 20 dwells -> exactly one key_press
//    with key_code=5 (phone map: 6); key_down=1 until release.
//  3 Bounce: col_in[2] toggles every dwell while row 1 is driven -> no key_press; row_drv keeps
//    rotating 0001->0010->0100->1000->0001.
//  4 Priority: cols 0 and 2 pressed on row 2 -> key_code=6 (phone map: 7); col 2 is ignored.
//  5 Release: after test 2, drop col_in -> key_release strobe 1 cycle after the 3rd low sample;
//    key_code stays 5; scanning resumes at row_drv=4'b0100.
//  6 Reset mid-debounce: assert rst_n=0 after the 2nd matching sample -> no key_press;
//    row_drv=4'b0001 on the next cycle.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Bundles the keypad pin signals and the decoded key outputs of the keypad
//   scanner so they travel as a single port.
//   Signals:
//     col_in      raw column lines from the keypad, active-high
//     row_drv     one-hot row drive towards the keypad
//     key_code    code of the current/last accepted key
//     key_press   one-cycle strobe on an accepted press
//     key_release one-cycle strobe on an accepted release
//     key_down    level, high while a key is held
//   Modports:
//     master  the scanner (reads columns, drives rows and key outputs)
//     slave   the keypad/consumer side
//   Build option: KEYPAD_PHONE_MAP_EN fixes the code width at 4 bits.
interface keypad_scanner_if #(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 3
);
`ifdef KEYPAD_PHONE_MAP_EN
    localparam int CODE_W = 4;
`else
    localparam int CODE_W = $clog2(NUM_ROWS * NUM_COLS);
`endif

    logic [NUM_COLS-1:0] col_in;
    logic [NUM_ROWS-1:0] row_drv;
    logic [CODE_W-1:0]   key_code;
    logic                key_press;
    logic                key_release;
    logic                key_down;

    modport master (
        input  col_in,
        output row_drv, key_code, key_press, key_release, key_down
    );

    modport slave (
        output col_in,
        input  row_drv, key_code, key_press, key_release, key_down
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Matrix keypad scanner. Drives the rows one-hot, dwelling SCAN_DIV clocks
//   on each row, samples the synchronised columns at the end of each dwell,
//   and debounces both press and release over DEBOUNCE_SCANS samples. Emits
//   one-shot press/release strobes, a held-key level and the key code.
//   Ports:
//     clk    system clock
//     rst_n  synchronous reset, active-low
//     bus    keypad_scanner_if.master (col_in in; row_drv, key_code,
//            key_press, key_release, key_down out)
//   Build option: KEYPAD_PHONE_MAP_EN selects the telephone key layout
//   (4x3 keypads only); otherwise code = row*NUM_COLS + col.
module keypad_scanner #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 3,
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst_n,
    keypad_scanner_if.master bus
);
    localparam int ROW_W   = $clog2(NUM_ROWS);
    localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int CNT_W   = $clog2(SCAN_DIV);
    localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);
`ifdef KEYPAD_PHONE_MAP_EN
    localparam int CODE_W  = 4;
`else
    localparam int CODE_W  = $clog2(NUM_ROWS * NUM_COLS);
`endif

    if (NUM_ROWS < 2 || NUM_COLS < 1 || SCAN_DIV < 3 || DEBOUNCE_SCANS < 1) begin : gParamErr
        $error("keypad_scanner: illegal parameter combination");
    end
`ifdef KEYPAD_PHONE_MAP_EN
    if (NUM_ROWS != 4 || NUM_COLS != 3) begin : gPhoneErr
        $error("keypad_scanner: telephone map needs NUM_ROWS=4 and NUM_COLS=3");
    end
`endif

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t              state_q, state_d;
    logic [NUM_COLS-1:0] colMeta_q, colSync_q;
    logic [CNT_W-1:0]    dwellCnt_q, dwellCnt_d;
    logic [ROW_W-1:0]    rowIdx_q, rowIdx_d;
    logic [NUM_ROWS-1:0] rowDrv_q, rowDrv_d;
    logic [COL_W-1:0]    colIdx_q, colIdx_d;
    logic [MATCH_W-1:0]  matchCnt_q, matchCnt_d;
    logic [CODE_W-1:0]   keyCode_q, keyCode_d;
    logic                keyPress_q, keyPress_d;
    logic                keyRelease_q, keyRelease_d;
    logic                keyDown_q, keyDown_d;

    logic                sample;
    logic                colHit;
    logic                matchDone;
    logic [MATCH_W-1:0]  matchInc;
    logic [ROW_W-1:0]    nextRow;

    // Lowest-index pressed column wins when several are active.
    function automatic logic [COL_W-1:0] lowestCol(input logic [NUM_COLS-1:0] v);
        lowestCol = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (v[i]) lowestCol = COL_W'(i);
        end
    endfunction

    function automatic logic [CODE_W-1:0] mapKey(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
`ifdef KEYPAD_PHONE_MAP_EN
        logic [3:0] phone [12];
        phone = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                  4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd11};
        mapKey = phone[int'(r) * NUM_COLS + int'(c)];
`else
        mapKey = CODE_W'(int'(r) * NUM_COLS + int'(c));
`endif
    endfunction

    assign sample    = (dwellCnt_q == CNT_W'(SCAN_DIV - 1));
    assign colHit    = colSync_q[colIdx_q];
    assign matchInc  = matchCnt_q + MATCH_W'(1);
    assign matchDone = (matchInc == MATCH_W'(DEBOUNCE_SCANS));
    assign nextRow   = (rowIdx_q == ROW_W'(NUM_ROWS - 1)) ? '0 : rowIdx_q + ROW_W'(1);

    // State register, column synchroniser and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SCAN;
            colMeta_q    <= '0;
            colSync_q    <= '0;
            dwellCnt_q   <= '0;
            rowIdx_q     <= '0;
            rowDrv_q     <= {{(NUM_ROWS-1){1'b0}}, 1'b1};
            colIdx_q     <= '0;
            matchCnt_q   <= '0;
            keyCode_q    <= '0;
            keyPress_q   <= 1'b0;
            keyRelease_q <= 1'b0;
            keyDown_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            colMeta_q    <= bus.col_in;
            colSync_q    <= colMeta_q;
            dwellCnt_q   <= dwellCnt_d;
            rowIdx_q     <= rowIdx_d;
            rowDrv_q     <= rowDrv_d;
            colIdx_q     <= colIdx_d;
            matchCnt_q   <= matchCnt_d;
            keyCode_q    <= keyCode_d;
            keyPress_q   <= keyPress_d;
            keyRelease_q <= keyRelease_d;
            keyDown_q    <= keyDown_d;
        end
    end

    // Next-state logic. Rows and states only change on a sample, so the
    // dwell counter clearing on a sample also clears it on every change.
    always_comb begin
        state_d    = state_q;
        rowIdx_d   = rowIdx_q;
        colIdx_d   = colIdx_q;
        matchCnt_d = matchCnt_q;
        dwellCnt_d = sample ? '0 : dwellCnt_q + CNT_W'(1);
        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (colSync_q == '0) begin
                        rowIdx_d = nextRow;
                    end else begin
                        colIdx_d = lowestCol(colSync_q);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d    = HELD;
                            matchCnt_d = '0;
                        end else begin
                            state_d    = DEBOUNCE;
                            matchCnt_d = MATCH_W'(1);
                        end
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (!colHit) begin
                        state_d    = SCAN;
                        rowIdx_d   = nextRow;
                        matchCnt_d = '0;
                    end else if (matchDone) begin
                        state_d    = HELD;
                        matchCnt_d = '0;
                    end else begin
                        matchCnt_d = matchInc;
                    end
                end
            end
            HELD: begin
                // Only the latched column matters; other keys are ignored.
                if (sample) begin
                    if (colHit) begin
                        matchCnt_d = '0;
                    end else if (matchDone) begin
                        state_d    = SCAN;
                        rowIdx_d   = nextRow;
                        matchCnt_d = '0;
                    end else begin
                        matchCnt_d = matchInc;
                    end
                end
            end
            default: begin
                state_d    = SCAN;
                matchCnt_d = '0;
            end
        endcase
    end

    // Output logic. key_down falls the cycle after the release strobe.
    always_comb begin
        rowDrv_d     = {{(NUM_ROWS-1){1'b0}}, 1'b1} << rowIdx_d;
        keyPress_d   = (state_d == HELD) && (state_q != HELD);
        keyRelease_d = (state_q == HELD) && (state_d == SCAN);
        keyCode_d    = keyCode_q;
        keyDown_d    = keyDown_q;
        if (keyPress_d) begin
            keyCode_d = mapKey(rowIdx_q, colIdx_d);
            keyDown_d = 1'b1;
        end else if (keyRelease_q) begin
            keyDown_d = 1'b0;
        end
    end

    assign bus.row_drv     = rowDrv_q;
    assign bus.key_code    = keyCode_q;
    assign bus.key_press   = keyPress_q;
    assign bus.key_release = keyRelease_q;
    assign bus.key_down    = keyDown_q;
endmodule
